// File: rtl/alu_sched_pkg.sv
// ============================================================================
// Module : alu_sched_pkg
// Brief  : Shared types and encodings for the SIMD ALU round-robin scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_sched_pkg;

  typedef struct packed {
    logic [3:0]  alumode;
    logic [8:0]  opmode;
    logic [1:0]  use_simd;
    logic [31:0] w;
    logic [31:0] z;
    logic [31:0] y;
    logic [31:0] x;
    logic        cin;
  } alu_cmd_t;

  typedef enum logic [0:0] {
    ARB     = 1'b0,
    LOCK_HI = 1'b1
  } sched_state_e;

  localparam logic [1:0] MODE_16x16   = 2'b00;
  localparam logic [1:0] MODE_SUM_8x8 = 2'b01;
  localparam logic [1:0] MODE_SUM_4x4 = 2'b10;
  localparam logic [1:0] MODE_SUM_2x2 = 2'b11;

  // A low beat must run unsegmented so its carry can chain into the high beat.
  function automatic logic cmd_illegal(input logic [3:0] alumode,
                                       input logic [1:0] use_simd,
                                       input logic       lo_beat);
    return (alumode[3:2] == 2'b10) || (lo_beat && (use_simd != MODE_16x16));
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_simd_rr_scheduler_arb.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin grant: first requester at or after ptr, one-hot out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id,
  output logic               any
);

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[wrap_idx(int'(ptr), i)]) begin
        grant[wrap_idx(int'(ptr), i)] = 1'b1;
        grant_id                      = IDW'(wrap_idx(int'(ptr), i));
        any                           = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_simd_rr_scheduler.sv
// ============================================================================
// Module : alu_simd_rr_scheduler
// Brief  : Round-robin share of one 32-bit SIMD ALU with 64-bit locked adds.
//          Optional illegal-command screening: ALU_SCHED_ILLEGAL_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_simd_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_alumode,
  input  logic [9*NUM_REQ-1:0]  req_opmode,
  input  logic [2*NUM_REQ-1:0]  req_use_simd,
  input  logic [32*NUM_REQ-1:0] req_w,
  input  logic [32*NUM_REQ-1:0] req_z,
  input  logic [32*NUM_REQ-1:0] req_y,
  input  logic [32*NUM_REQ-1:0] req_x,
  input  logic [NUM_REQ-1:0]    req_cin,
  input  logic [NUM_REQ-1:0]    req_wide,
  output logic [3:0]            alu_alumode,
  output logic [8:0]            alu_opmode,
  output logic [1:0]            alu_use_simd,
  output logic [31:0]           alu_w,
  output logic [31:0]           alu_z,
  output logic [31:0]           alu_y,
  output logic [31:0]           alu_x,
  output logic                  alu_cin,
  output logic [7:0]            alu_carry_in,
  input  logic [31:0]           alu_s,
  input  logic [7:0]            alu_carry_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_s,
  output logic [7:0]            rsp_carry,
  output logic                  rsp_hi,
  output logic                  rsp_err
);

  sched_state_e state, state_nxt;
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0] lock_id, lock_id_nxt;
  logic           hi_carry;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDW-1:0]     arb_id;
  logic               arb_any;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic               grant_any;

  logic     rsp_adv, can_issue, accept;
  alu_cmd_t sel_cmd, iss_cmd_nxt;
  logic     sel_wide, sel_err, is_lo, is_hi;

  alu_cmd_t       iss_cmd;
  logic           iss_valid, iss_lo, iss_hi, iss_err;
  logic [IDW-1:0] iss_id;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (int'(id) >= NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .any      (arb_any)
  );

  assign rsp_adv   = !rsp_valid || rsp_ready;
  assign can_issue = (!iss_valid || rsp_adv) && !reset;

  always_comb begin
    grant     = '0;
    grant_id  = arb_id;
    grant_any = 1'b0;
    if (state == ARB) begin
      grant     = arb_grant;
      grant_any = arb_any;
    end else begin
      grant_id = lock_id;
      if (req_valid[lock_id]) begin
        grant[lock_id] = 1'b1;
        grant_any      = 1'b1;
      end
    end
  end

  assign req_ready = can_issue ? grant : '0;
  assign accept    = can_issue && grant_any;

  always_comb begin
    sel_cmd.alumode  = req_alumode[4*grant_id +: 4];
    sel_cmd.opmode   = req_opmode[9*grant_id +: 9];
    sel_cmd.use_simd = req_use_simd[2*grant_id +: 2];
    sel_cmd.w        = req_w[32*grant_id +: 32];
    sel_cmd.z        = req_z[32*grant_id +: 32];
    sel_cmd.y        = req_y[32*grant_id +: 32];
    sel_cmd.x        = req_x[32*grant_id +: 32];
    sel_cmd.cin      = req_cin[grant_id];
    sel_wide         = req_wide[grant_id];
  end

`ifdef ALU_SCHED_ILLEGAL_CHECK_EN
  assign sel_err = cmd_illegal(sel_cmd.alumode, sel_cmd.use_simd,
                               sel_wide && (state == ARB));
`else
  assign sel_err = 1'b0;
`endif

  assign is_lo = (state == ARB) && sel_wide && !sel_err;
  assign is_hi = (state == LOCK_HI);

  // A high beat accepted while its low beat is still leaving ISSUE takes the
  // carry straight from the ALU; otherwise the low result was captured already.
  always_comb begin
    iss_cmd_nxt = sel_cmd;
    if (is_lo || is_hi) iss_cmd_nxt.use_simd = MODE_16x16;
    if (is_hi) iss_cmd_nxt.cin = (iss_valid && iss_lo) ? alu_carry_out[7] : hi_carry;
    if (sel_err) iss_cmd_nxt = '0;
  end

  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    lock_id_nxt = lock_id;
    if (accept) begin
      if (state == ARB) begin
        if (is_lo) begin
          state_nxt   = LOCK_HI;
          lock_id_nxt = grant_id;
        end else begin
          rr_ptr_nxt = next_id(grant_id);
        end
      end else begin
        state_nxt  = ARB;
        rr_ptr_nxt = next_id(lock_id);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      lock_id <= lock_id_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_valid <= 1'b0;
      iss_cmd   <= '0;
      iss_id    <= '0;
      iss_lo    <= 1'b0;
      iss_hi    <= 1'b0;
      iss_err   <= 1'b0;
      hi_carry  <= 1'b0;
    end else begin
      if (iss_valid && iss_lo && rsp_adv) hi_carry <= alu_carry_out[7];
      if (can_issue) begin
        iss_valid <= accept;
        if (accept) begin
          iss_cmd <= iss_cmd_nxt;
          iss_id  <= grant_id;
          iss_lo  <= is_lo;
          iss_hi  <= is_hi;
          iss_err <= sel_err;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_s     <= '0;
      rsp_carry <= '0;
      rsp_hi    <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (rsp_adv) begin
      rsp_valid <= iss_valid;
      if (iss_valid) begin
        rsp_id    <= iss_id;
        rsp_s     <= iss_err ? 32'd0 : alu_s;
        rsp_carry <= iss_err ? 8'd0 : alu_carry_out;
        rsp_hi    <= iss_hi;
        rsp_err   <= iss_err;
      end
    end
  end

  assign alu_alumode  = iss_cmd.alumode;
  assign alu_opmode   = iss_cmd.opmode;
  assign alu_use_simd = iss_cmd.use_simd;
  assign alu_w        = iss_cmd.w;
  assign alu_z        = iss_cmd.z;
  assign alu_y        = iss_cmd.y;
  assign alu_x        = iss_cmd.x;
  assign alu_cin      = iss_cmd.cin;
  assign alu_carry_in = 8'd0;

endmodule

`default_nettype wire
